// File: rtl/mux_arbiter_2to1.sv
// Arbiter and sequencer for a 2-to-1 datapath mux with a registered valid/ready output stage.
// Default policy is round-robin with a burst limit; define MUX_ARB_FIXED_PRIO_EN for fixed priority (A highest).
module mux_arbiter_2to1 #(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ReqA,
  input  logic [WIDTH-1:0] DatoA,
  output logic             AckA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] DatoB,
  output logic             AckB,
  output logic             Sel,
  output logic [WIDTH-1:0] Salida,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERV_A = 2'd1;
  localparam logic [1:0] SERV_B = 2'd2;

  logic [1:0] state;
  logic [1:0] next_state;
  logic       settle;
  logic       out_free;
  logic       xfer_in;

  // settle blanks the first cycle after a grant hand-over that followed a transfer,
  // so the new Sel value reaches the mux before any Ack is issued.
  assign out_free = !OutValid || OutReady;
  assign AckA     = (state == SERV_A) && !settle && ReqA && out_free;
  assign AckB     = (state == SERV_B) && !settle && ReqB && out_free;
  assign xfer_in  = AckA || AckB;
  assign Busy     = (state != IDLE);

`ifdef MUX_ARB_FIXED_PRIO_EN
  // NOTE: next_state gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ReqA)      next_state = SERV_A;
        else if (ReqB) next_state = SERV_B;
      end
      SERV_A: begin
        if (!ReqA) next_state = ReqB ? SERV_B : IDLE;
      end
      SERV_B: begin
        // A preempts B right after the current B word, or at once if B is stalled.
        if (!ReqB || ReqA) next_state = ReqA ? SERV_A : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end
`else
  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  logic [3:0] count;
  logic [3:0] next_count;
  logic [3:0] count_inc;
  logic       last_grant;       // 1 = B was served last
  logic       next_last_grant;

  // Saturates so a lone requester keeps streaming and yields on its next word.
  assign count_inc = (count == BURST_MAX) ? count : count + 4'd1;

  always_comb begin
    next_state      = state;
    next_count      = count;
    next_last_grant = last_grant;
    case (state)
      IDLE: begin
        if (ReqA && (!ReqB || last_grant)) next_state = SERV_A;
        else if (ReqB)                     next_state = SERV_B;
      end
      SERV_A: begin
        if (!ReqA) begin
          next_state      = ReqB ? SERV_B : IDLE;
          next_count      = '0;
          next_last_grant = 1'b0;
        end else if (AckA) begin
          if (count_inc == BURST_MAX && ReqB) begin
            next_state      = SERV_B;
            next_count      = '0;
            next_last_grant = 1'b0;
          end else begin
            next_count = count_inc;
          end
        end
      end
      SERV_B: begin
        if (!ReqB) begin
          next_state      = ReqA ? SERV_A : IDLE;
          next_count      = '0;
          next_last_grant = 1'b1;
        end else if (AckB) begin
          if (count_inc == BURST_MAX && ReqA) begin
            next_state      = SERV_A;
            next_count      = '0;
            next_last_grant = 1'b1;
          end else begin
            next_count = count_inc;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      count      <= next_count;
      last_grant <= next_last_grant;
    end
  end
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      settle   <= 1'b0;
      Sel      <= 1'b0;
      Salida   <= '0;
      OutValid <= 1'b0;
    end else begin
      state  <= next_state;
      settle <= xfer_in && (next_state != state) && (next_state != IDLE);

      if (next_state == SERV_A)      Sel <= 1'b0;
      else if (next_state == SERV_B) Sel <= 1'b1;

      if (xfer_in) begin
        Salida   <= Sel ? DatoB : DatoA;
        OutValid <= 1'b1;
      end else if (OutReady) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Directed bench for mux_arbiter_2to1: per-cycle Ack/Sel expectations plus an output scoreboard.
module tb_mux_arbiter_2to1;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             ReqA;
  logic [WIDTH-1:0] DatoA;
  logic             AckA;
  logic             ReqB;
  logic [WIDTH-1:0] DatoB;
  logic             AckB;
  logic             Sel;
  logic [WIDTH-1:0] Salida;
  logic             OutValid;
  logic             OutReady;
  logic             Busy;

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [WIDTH-1:0] sb[$];

  int checks = 0;
  int errors = 0;

  mux_arbiter_2to1 #(.WIDTH(WIDTH), .BURST_LEN(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ReqA     (ReqA),
    .DatoA    (DatoA),
    .AckA     (AckA),
    .ReqB     (ReqB),
    .DatoB    (DatoB),
    .AckB     (AckB),
    .Sel      (Sel),
    .Salida   (Salida),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Busy     (Busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One character per cycle: pr = OutReady, pa/pb = expected AckA/AckB, ps = expected Sel ('-' = any).
  // Entered and left at posedge+1; requesters present the head of qa/qb while non-empty.
  task automatic run(input string pr, input string pa, input string pb, input string ps,
                     input string tag);
    for (int i = 0; i < pa.len(); i++) begin
      OutReady = (pr[i] == "1");
      ReqA     = (qa.size() > 0);
      DatoA    = ReqA ? qa[0] : '0;
      ReqB     = (qb.size() > 0);
      DatoB    = ReqB ? qb[0] : '0;
      #1;
      check($sformatf("%s_ack_a[%0d]", tag, i), AckA, pa[i] == "1");
      check($sformatf("%s_ack_b[%0d]", tag, i), AckB, pb[i] == "1");
      if (ps[i] != "-") check($sformatf("%s_sel[%0d]", tag, i), Sel, ps[i] == "1");
      if (OutValid && OutReady) begin
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL %s_extra[%0d] got=%h expected=none", tag, i, Salida);
        end
        if (sb.size() > 0) check($sformatf("%s_data[%0d]", tag, i), Salida, sb.pop_front());
      end
      if (pa[i] == "1" && qa.size() > 0) sb.push_back(qa[0]);
      if (pb[i] == "1" && qb.size() > 0) sb.push_back(qb[0]);
      if (AckA && qa.size() > 0) void'(qa.pop_front());
      if (AckB && qb.size() > 0) void'(qb.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    ReqA     = 1'b0;
    ReqB     = 1'b0;
    DatoA    = '0;
    DatoB    = '0;
    OutReady = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", OutValid, 0);
    check("rst_salida",    Salida,   0);
    check("rst_sel",       Sel,      0);
    check("rst_busy",      Busy,     0);
    check("rst_ack_a",     AckA,     0);
    check("rst_ack_b",     AckB,     0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester: 6 words back to back after a one-cycle grant.
    for (int k = 1; k <= 6; k++) qa.push_back(16'(k * 'h1111));
    run("111111111", "011111100", "000000000", "000000000", "single_a");
    check("single_a_drain", 32'(sb.size()), 0);
    check("single_a_busy", Busy, 0);

    // Asynchronous reset in the middle of a B burst with a word held in Salida.
    for (int k = 1; k <= 3; k++) qb.push_back(16'('hB000 + k));
    run("111", "000", "011", "011", "burst_b");
    check("pre_rst_valid", OutValid, 1);
    check("pre_rst_sel", Sel, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", OutValid, 0);
    check("mid_rst_salida",    Salida,   0);
    check("mid_rst_sel",       Sel,      0);
    check("mid_rst_busy",      Busy,     0);
    check("mid_rst_ack_b",     AckB,     0);
    sb.delete();
    qb.delete();
    ReqB  = 1'b0;
    DatoB = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifndef MUX_ARB_FIXED_PRIO_EN
    // Contention: 4 A, bubble, 4 B, bubble, 4 A, bubble, 4 B; A wins the first tie.
    for (int k = 1; k <= 8; k++) qa.push_back(16'('hA000 + k));
    for (int k = 1; k <= 8; k++) qb.push_back(16'('hB100 + k));
    run("111111111111111111111",
        "011110000001111000000",
        "000000111100000011110",
        "000001111100000111111", "contend");
    check("contend_drain", 32'(sb.size()), 0);
    check("contend_busy", Busy, 0);
`endif

    // Backpressure: first word stalls in Salida for 5 cycles, next word taken on release.
    qa.push_back(16'h1111);
    qa.push_back(16'hAAAA);
    run("00", "01", "00", "-0", "bp_first");
    for (int k = 0; k < 5; k++) begin
      run("0", "0", "0", "0", $sformatf("bp_hold%0d", k));
      check($sformatf("bp_hold%0d_valid", k), OutValid, 1);
      check($sformatf("bp_hold%0d_salida", k), Salida, 16'h1111);
    end
    run("11", "10", "00", "00", "bp_release");
    check("bp_drain", 32'(sb.size()), 0);

    // Requester drop: B stops with A idle -> IDLE next cycle, Sel keeps B.
    qb.push_back(16'hC001);
    qb.push_back(16'hC002);
    run("1111", "0000", "0110", "0111", "drop");
    check("drop_busy", Busy, 0);
    check("drop_sel", Sel, 1);
    check("drop_valid", OutValid, 0);

`ifdef MUX_ARB_FIXED_PRIO_EN
    // Fixed priority: A arrives while B streams, takes over after B's word, runs 10 words.
    for (int k = 1; k <= 3; k++) qb.push_back(16'('hD000 + k));
    run("11", "00", "01", "11", "fixed_b");
    for (int k = 1; k <= 10; k++) qa.push_back(16'('hE000 + k));
    run("111111111111111",
        "001111111111000",
        "100000000000010",
        "100000000000011", "fixed_a");
    check("fixed_drain", 32'(sb.size()), 0);
    check("fixed_busy", Busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
